ia_packet_rx: RTL and testbench

- Parametrised successor to the fixed 55-byte UART input assembler.
- Consumes the byte stream from the UART receiver (rx_data_out / rx_done_tick) and frames it as packets: sync byte, then NUM_BYTES payload bytes.
- Emits one indexed register-update strobe per payload byte and one packet-complete strobe (pc_ready) per good packet.
- Adds sync detection, an inter-byte timeout and an optional checksum, none of which the previous block had.

---
 rtl/ia_packet_rx.sv | 124 ++++++++++++
 tb/tb_ia_packet_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ia_packet_rx.sv
// rtl/ia_packet_rx.sv - frames UART bytes into SYNC + NUM_BYTES packets with indexed update strobes.
// Optional payload XOR checksum byte enabled by defining IA_PACKET_RX_CHECKSUM_EN.
module ia_packet_rx #(
  parameter int         NUM_BYTES      = 55,
  parameter int         IDX_W          = 6,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [7:0]       read_data,
  output logic [IDX_W-1:0] idx,
  output logic             update_reg,
  output logic             pc_ready,
  output logic             pkt_err
);

  typedef enum logic [1:0] {IDLE, RECV, DONE, CSUM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [IDX_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             to_expire;

`ifdef IA_PACKET_RX_CHECKSUM_EN
  logic [7:0] csum;
`endif

  // Expiry fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES;
  // a byte arriving in that same cycle takes priority.
  assign to_expire = TO_EN && !byte_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      to_cnt     <= '0;
      read_data  <= '0;
      idx        <= '0;
      update_reg <= 1'b0;
      pc_ready   <= 1'b0;
      pkt_err    <= 1'b0;
`ifdef IA_PACKET_RX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      update_reg <= 1'b0;
      pc_ready   <= 1'b0;
      pkt_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid && (byte_data == SYNC_BYTE)) begin
            state  <= RECV;
            cnt    <= '0;
            to_cnt <= '0;
`ifdef IA_PACKET_RX_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        RECV: begin
          if (byte_valid) begin
            read_data  <= byte_data;
            idx        <= cnt;
            update_reg <= 1'b1;
            to_cnt     <= '0;
`ifdef IA_PACKET_RX_CHECKSUM_EN
            csum       <= csum ^ byte_data;
`endif
            if (cnt == LAST_IDX) begin
`ifdef IA_PACKET_RX_CHECKSUM_EN
              state <= CSUM;
`else
              state <= DONE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (to_expire) begin
            pkt_err <= 1'b1;
            state   <= IDLE;
            to_cnt  <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef IA_PACKET_RX_CHECKSUM_EN
        CSUM: begin
          if (byte_valid) begin
            to_cnt <= '0;
            if (byte_data == csum) begin
              state <= DONE;
            end else begin
              pkt_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (to_expire) begin
            pkt_err <= 1'b1;
            state   <= IDLE;
            to_cnt  <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          // Any byte arriving here is dropped, never treated as a new sync.
          pc_ready <= 1'b1;
          state    <= IDLE;
          cnt      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ia_packet_rx.sv
// tb/tb_ia_packet_rx.sv - scoreboard bench for ia_packet_rx (NUM_BYTES=4 and NUM_BYTES=1 instances).
module tb_ia_packet_rx;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       byte_valid, bv1;
  logic [7:0] byte_data, bd1;
  logic [7:0] read_data, rd1;
  logic [5:0] idx, idx1;
  logic       update_reg, pc_ready, pkt_err;
  logic       upd1, pc1, err1;

  always #5 clk = ~clk;

  ia_packet_rx #(.NUM_BYTES(4), .IDX_W(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(20)) u0 (
    .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .read_data(read_data), .idx(idx), .update_reg(update_reg), .pc_ready(pc_ready), .pkt_err(pkt_err));

  ia_packet_rx #(.NUM_BYTES(1), .IDX_W(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(20)) u1 (
    .clk(clk), .reset_n(reset_n), .byte_valid(bv1), .byte_data(bd1),
    .read_data(rd1), .idx(idx1), .update_reg(upd1), .pc_ready(pc1), .pkt_err(err1));

  typedef struct {
    int         kind;
    logic [5:0] i;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    int         gap;
    bit         upd;
    logic [5:0] i;
    bit         last;
  } vec_t;

  ev_t  expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_upd_cyc = -100;
  int   last_byte_cyc = 0;
  bit   chk_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input logic [5:0] i, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.i = i; e.d = d;
    expq.push_back(e);
  endtask

  task automatic observe(input int k, input logic [5:0] i, input logic [7:0] d);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d idx %0d data %0h expected none", k, i, d);
    end else begin
      e = expq.pop_front();
      check("strobe_kind", k, e.kind);
      if (k == 0) begin
        check("upd_idx", i, e.i);
        check("upd_data", d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (update_reg) begin
        observe(0, idx, read_data);
        last_upd_cyc = cyc;
      end
      if (pc_ready) begin
        observe(1, 0, 0);
`ifndef IA_PACKET_RX_CHECKSUM_EN
        check("pc_after_last_upd", cyc - last_upd_cyc, 1);
`endif
      end
      if (pkt_err) begin
        observe(2, 0, 0);
        if (chk_gap) check("timeout_gap", cyc - last_byte_cyc, TO);
      end
    end
  end

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    last_byte_cyc = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] p [4], input int gap);
    logic [7:0] x;
    x = 8'h00;
    send(8'hA5, gap);
    for (int k = 0; k < 4; k++) begin
      push_ev(0, 6'(k), p[k]);
      x ^= p[k];
    end
    push_ev(1, 0, 0);
    for (int k = 0; k < 4; k++) send(p[k], gap);
`ifdef IA_PACKET_RX_CHECKSUM_EN
    send(x, gap);
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [11];
    logic [7:0] x;

    tbl[0]  = '{8'h00, 10, 1'b0, 6'd0, 1'b0};
    tbl[1]  = '{8'hA5, 10, 1'b0, 6'd0, 1'b0};
    tbl[2]  = '{8'h11, 10, 1'b1, 6'd0, 1'b0};
    tbl[3]  = '{8'h22, 10, 1'b1, 6'd1, 1'b0};
    tbl[4]  = '{8'h33, 10, 1'b1, 6'd2, 1'b0};
    tbl[5]  = '{8'h44, 10, 1'b1, 6'd3, 1'b1};
    tbl[6]  = '{8'hA5,  2, 1'b0, 6'd0, 1'b0};
    tbl[7]  = '{8'hA5,  2, 1'b1, 6'd0, 1'b0};
    tbl[8]  = '{8'hA5,  2, 1'b1, 6'd1, 1'b0};
    tbl[9]  = '{8'hA5,  2, 1'b1, 6'd2, 1'b0};
    tbl[10] = '{8'hA5,  2, 1'b1, 6'd3, 1'b1};

    reset_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; bv1 = 1'b0; bd1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 0);
    check("rst_idx", idx, 0);
    check("rst_strobes", {update_reg, pc_ready, pkt_err}, 0);
    check("rst_u1_strobes", {upd1, pc1, err1}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // NUM_BYTES=1 instance: sync, one byte, then packet complete.
    bv1 = 1'b1; bd1 = 8'hA5;
    @(negedge clk);
    bd1 = 8'h7E;
    @(negedge clk);
    bv1 = 1'b0;
    check("nb1_upd", upd1, 1);
    check("nb1_idx", idx1, 0);
    check("nb1_data", rd1, 8'h7E);
`ifdef IA_PACKET_RX_CHECKSUM_EN
    bv1 = 1'b1; bd1 = 8'h7E;
    @(negedge clk);
    bv1 = 1'b0;
`endif
    @(negedge clk);
    check("nb1_pc", pc1, 1);
    check("nb1_err", err1, 0);

    // Table: gapped packet with leading junk, then all-sync payload.
    x = 8'h00;
    for (int r = 0; r < 11; r++) begin
      if (tbl[r].upd) begin
        push_ev(0, tbl[r].i, tbl[r].b);
        x ^= tbl[r].b;
      end
      if (tbl[r].last) push_ev(1, 0, 0);
      send(tbl[r].b, tbl[r].gap);
      if (tbl[r].last) begin
`ifdef IA_PACKET_RX_CHECKSUM_EN
        send(x, tbl[r].gap);
`endif
        x = 8'h00;
        drain("table_drain");
      end
    end

    // Timeout after two payload bytes, then a clean packet restarts at idx 0.
    chk_gap = 1'b1;
    push_ev(0, 6'd0, 8'h11);
    push_ev(0, 6'd1, 8'h22);
    push_ev(2, 0, 0);
    send(8'hA5, 3);
    send(8'h11, 3);
    send(8'h22, 60);
    drain("timeout_drain");
    chk_gap = 1'b0;
    send_pkt('{8'h01, 8'h02, 8'h03, 8'h04}, 3);
    drain("after_timeout_drain");

`ifdef IA_PACKET_RX_CHECKSUM_EN
    send_pkt('{8'h01, 8'h02, 8'h04, 8'h08}, 3);
    drain("csum_ok_drain");
    for (int k = 0; k < 4; k++) push_ev(0, 6'(k), 8'(1 << k));
    push_ev(2, 0, 0);
    send(8'hA5, 3);
    for (int k = 0; k < 4; k++) send(8'(1 << k), 3);
    send(8'h0E, 3);
    drain("csum_bad_drain");
`endif

    // Reset mid-packet: outputs clear asynchronously, stray bytes ignored afterwards.
    push_ev(0, 6'd0, 8'h11);
    send(8'hA5, 3);
    send(8'h11, 3);
    drain("pre_reset_drain");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", read_data, 0);
    check("async_rst_strobes", {update_reg, pc_ready, pkt_err}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(8'h22, 3);
    send(8'h33, 3);
    check("post_reset_hold", read_data, 0);
    send_pkt('{8'h10, 8'h20, 8'h30, 8'h40}, 3);
    drain("post_reset_drain");

    // Every byte lands exactly on the timeout-expiry cycle and must win.
    send_pkt('{8'h5A, 8'h5B, 8'h5C, 8'h5D}, TO - 1);
    drain("expiry_edge_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
